// File: rtl/cpu_pkg.sv
// Shared CPU constants: default address width, PC reset value and word size.
package cpu_pkg;

    localparam int unsigned ADDR_W        = 32;
    localparam logic [31:0] PC_RESET_ADDR = 32'h0000_0000;
    localparam int unsigned WORD_BYTES    = 4;

endpackage

// File: rtl/pc_align_check.sv
// Combinational word-alignment check for a next-PC candidate.
// Clears address bits [1:0] and flags whether either was set.
module pc_align_check
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W
) (
    input  logic [WIDTH-1:0] addr_i,
    output logic [WIDTH-1:0] addr_o,
    output logic             misalign_o
);

    always_comb begin
        addr_o      = {addr_i[WIDTH-1:2], 2'b00};
        misalign_o  = |addr_i[1:0];
    end

endmodule

// File: rtl/program_counter.sv
// IF-stage program counter with load enable and PC+4 output.
// Optional PC_ALIGN_CHECK_EN forces word-aligned loads and adds a registered misalign flag.
module program_counter
    import cpu_pkg::*;
#(
    parameter int unsigned      WIDTH      = ADDR_W,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(PC_RESET_ADDR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] new_addr,
    input  logic             pc_en,
    output logic [WIDTH-1:0] output_pc,
    output logic [WIDTH-1:0] pc_plus4
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic             misalign
`endif
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] load_addr;

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;
    logic misalign_d;
    logic load_misalign;

    pc_align_check #(
        .WIDTH (WIDTH)
    ) u_align (
        .addr_i     (new_addr),
        .addr_o     (load_addr),
        .misalign_o (load_misalign)
    );

    // Flag travels with the PC it describes, so it holds on stall too.
    always_comb begin
        misalign_d = misalign_q;
        if (pc_en) begin
            misalign_d = load_misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`else
    assign load_addr = new_addr;
`endif

    // Stall selects pc_q, so new_addr never reaches the register when pc_en is low.
    always_comb begin
        pc_d = pc_q;
        if (pc_en) begin
            pc_d = load_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign output_pc = pc_q;
    assign pc_plus4  = pc_q + WIDTH'(WORD_BYTES);

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter against a behavioural PC model.
module tb_program_counter;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic [W-1:0] new_addr;
    logic         pc_en;
    logic [W-1:0] output_pc;
    logic [W-1:0] pc_plus4;
`ifdef PC_ALIGN_CHECK_EN
    logic         misalign;
`endif

    int unsigned n_cmp;
    int unsigned n_err;

    // Reference state: address the PC should hold and its misalign flag.
    logic [W-1:0] exp_pc;
    logic         exp_mis;

    program_counter #(
        .WIDTH      (W),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .new_addr  (new_addr),
        .pc_en     (pc_en),
        .output_pc (output_pc),
        .pc_plus4  (pc_plus4)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign  (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance past the edge and update the model.
    task automatic tick(input logic r, input logic e, input logic [W-1:0] a);
        rst      = r;
        pc_en    = e;
        new_addr = a;
        @(posedge clk);
        if (r) begin
            exp_pc  = 32'h0;
            exp_mis = 1'b0;
        end else if (e) begin
`ifdef PC_ALIGN_CHECK_EN
            exp_pc  = a - (a % 4);
            exp_mis = (a % 4) != 0;
`else
            exp_pc  = a;
            exp_mis = 1'b0;
`endif
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1, 32'd12);
            n_cmp++;
            if (output_pc !== 32'h0) begin
                n_err++;
                $display("FAIL reset_hold cyc%0d: output_pc=%h required=%h", i, output_pc, 32'h0);
            end
`ifdef PC_ALIGN_CHECK_EN
            n_cmp++;
            if (misalign !== 1'b0) begin
                n_err++;
                $display("FAIL reset_misalign cyc%0d: misalign=%b required=0", i, misalign);
            end
`endif
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 32'($urandom_range(19, 0)));
            n_cmp++;
            if (output_pc !== 32'h0) begin
                n_err++;
                $display("FAIL stall cyc%0d: output_pc=%h required=%h", i, output_pc, 32'h0);
            end
        end
        rst      = 1'b0;
        pc_en    = 1'b0;
        new_addr = 'x;
        @(posedge clk);
        #1;
        n_cmp++;
        if (output_pc !== 32'h0) begin
            n_err++;
            $display("FAIL stall_unknown_addr: output_pc=%h required=%h", output_pc, 32'h0);
        end
    endtask

    task automatic test_load();
        logic [W-1:0] addrs [3];
        logic [W-1:0] pcs   [3];
        logic [W-1:0] plus  [3];
        addrs = '{32'd8, 32'd16, 32'd4};
        pcs   = '{32'd8, 32'd16, 32'd4};
        plus  = '{32'd12, 32'd20, 32'd8};
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, addrs[i]);
            n_cmp++;
            if (output_pc !== pcs[i]) begin
                n_err++;
                $display("FAIL load%0d: output_pc=%h required=%h", i, output_pc, pcs[i]);
            end
            n_cmp++;
            if (pc_plus4 !== plus[i]) begin
                n_err++;
                $display("FAIL load_plus4_%0d: pc_plus4=%h required=%h", i, pc_plus4, plus[i]);
            end
        end
    endtask

    task automatic test_align();
        logic [W-1:0] req13;
`ifdef PC_ALIGN_CHECK_EN
        req13 = 32'd12;
`else
        req13 = 32'd13;
`endif
        tick(1'b0, 1'b1, 32'd13);
        n_cmp++;
        if (output_pc !== req13) begin
            n_err++;
            $display("FAIL align13: output_pc=%h required=%h", output_pc, req13);
        end
`ifdef PC_ALIGN_CHECK_EN
        n_cmp++;
        if (misalign !== 1'b1) begin
            n_err++;
            $display("FAIL align13_flag: misalign=%b required=1", misalign);
        end
        tick(1'b0, 1'b0, 32'd8);
        n_cmp++;
        if (misalign !== 1'b1) begin
            n_err++;
            $display("FAIL align_stall_flag: misalign=%b required=1", misalign);
        end
`endif
        tick(1'b0, 1'b1, 32'd8);
        n_cmp++;
        if (output_pc !== 32'd8) begin
            n_err++;
            $display("FAIL align8: output_pc=%h required=%h", output_pc, 32'd8);
        end
`ifdef PC_ALIGN_CHECK_EN
        n_cmp++;
        if (misalign !== 1'b0) begin
            n_err++;
            $display("FAIL align8_flag: misalign=%b required=0", misalign);
        end
`endif
    endtask

    task automatic test_wrap();
        tick(1'b0, 1'b1, 32'hFFFF_FFFC);
        n_cmp++;
        if (output_pc !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_pc: output_pc=%h required=%h", output_pc, 32'hFFFF_FFFC);
        end
        n_cmp++;
        if (pc_plus4 !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL wrap_plus4: pc_plus4=%h required=%h", pc_plus4, 32'h0);
        end
    endtask

    task automatic test_midrun_reset();
        tick(1'b0, 1'b1, 32'd16);
        tick(1'b1, 1'b1, 32'd40);
        n_cmp++;
        if (output_pc !== 32'h0) begin
            n_err++;
            $display("FAIL midrun_reset: output_pc=%h required=%h", output_pc, 32'h0);
        end
        tick(1'b0, 1'b1, 32'd24);
        n_cmp++;
        if (output_pc !== 32'd24) begin
            n_err++;
            $display("FAIL midrun_resume: output_pc=%h required=%h", output_pc, 32'd24);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            logic         r;
            logic         e;
            logic [W-1:0] a;
            r = ($urandom_range(15, 0) == 0);
            e = $urandom_range(1, 0);
            a = $urandom();
            if ($urandom_range(3, 0) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
            tick(r, e, a);
            n_cmp++;
            if (output_pc !== exp_pc) begin
                n_err++;
                $display("FAIL rand_pc cyc%0d: output_pc=%h required=%h", i, output_pc, exp_pc);
            end
            n_cmp++;
            if (pc_plus4 !== exp_pc + 32'd4) begin
                n_err++;
                $display("FAIL rand_plus4 cyc%0d: pc_plus4=%h required=%h", i, pc_plus4, exp_pc + 32'd4);
            end
`ifdef PC_ALIGN_CHECK_EN
            n_cmp++;
            if (misalign !== exp_mis) begin
                n_err++;
                $display("FAIL rand_misalign cyc%0d: misalign=%b required=%b", i, misalign, exp_mis);
            end
`endif
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        exp_pc   = '0;
        exp_mis  = 1'b0;
        rst      = 1'b1;
        pc_en    = 1'b1;
        new_addr = 32'd12;
        test_reset();
        test_stall();
        test_load();
        test_align();
        test_wrap();
        test_midrun_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/program_counter.md
# program_counter

Program counter register for the 5-stage MIPS core's IF stage. Holds the current fetch address and presents it to instruction memory. It loads the next-PC value computed upstream (sequential, branch or jump) only when the pipeline allows, so that hazard logic can freeze fetch. It also provides a PC+4 convenience output for the next-PC mux.

## Interface
- WIDTH, 32: address width in bits; minimum 8.
- RESET_ADDR, 32'h0000_0000: value loaded on reset; must be word-aligned (bits [1:0] = 0).

- clk  input  1  rising-edge clock; sole clock domain.
- rst  input  1  reset; synchronous, active-high; dominates all other inputs.
- new_addr  input  WIDTH  next-PC candidate from the next-PC mux.
- pc_en  input  1  load enable; 0 = stall (hold current PC).
- output_pc  output  WIDTH  current PC, registered.
- pc_plus4  output  WIDTH  output_pc + 4, combinational, modulo 2^WIDTH.
- misalign  output  1  registered flag; present only with PC_ALIGN_CHECK_EN (see Configuration).

## Operation
- Single register pc_q drives output_pc directly; no combinational path from new_addr to output_pc.
- Priority at each rising edge of clk:
  - rst = 1: pc_q <= RESET_ADDR; misalign <= 0. pc_en and new_addr are ignored.
  - rst = 0, pc_en = 1: pc_q <= new_addr (alignment handling per Configuration).
  - rst = 0, pc_en = 0: pc_q holds.
- pc_plus4 = output_pc + 4, truncated to WIDTH bits. All-ones-region wrap (e.g. 32'hFFFF_FFFC -> 32'h0000_0000) is legal and silent.
- No internal increment: sequential fetch is done upstream by feeding pc_plus4 back through new_addr.
- X/unknown on new_addr while pc_en = 0 must not affect output_pc.

## Timing
- Load latency: 1 cycle. new_addr sampled at edge N appears on output_pc after edge N.
- Reset: output_pc = RESET_ADDR after the first rising edge with rst = 1. Value before the first reset edge is undefined.
- Reset released and pc_en = 1 on the same edge: that edge loads new_addr. Reset released with pc_en = 0: PC holds RESET_ADDR until pc_en rises.
- Reset asserted mid-operation: takes effect at the next edge regardless of pc_en.
- Stall of any length holds output_pc exactly. Toggling pc_en every cycle loads only on enabled edges.
- pc_plus4 settles combinationally within the same cycle as output_pc.

## Configuration
- Macro PC_ALIGN_CHECK_EN.
- Defined:
  - On a load, bits [1:0] of new_addr are forced to 0 in pc_q.
  - misalign <= |new_addr[1:0], registered alongside pc_q, so it is valid with the PC it describes.
  - misalign holds during stall and clears on reset.
- Not defined:
  - new_addr is loaded verbatim, including bits [1:0].
  - The misalign port does not exist.

## Structure
- Shared package cpu_pkg holds WIDTH default (ADDR_W = 32), RESET_ADDR default and the word-size constant 4.
- One sub-module: pc_align_check. Combinational; takes new_addr and returns the masked address and the misalign bit. It is instantiated only under PC_ALIGN_CHECK_EN.
- All other logic (register, priority, adder) stays in program_counter.

## Test plan
- Reset hold: rst = 1 for 5 cycles with pc_en = 1 and new_addr = 12 -> output_pc = 0 every cycle.
- Stall: rst = 0, pc_en = 0, new_addr random 0..19 each cycle for 5 cycles -> output_pc stays 0.
- Load:
  - Enable pc_en.
  - Drive new_addr = 8, then 16, then 4 on consecutive edges.
  - Required: output_pc = 8, 16, 4, one cycle late.
  - Required: pc_plus4 = 12, 20, 8.
- Alignment:
  - new_addr = 13 loaded.
  - With PC_ALIGN_CHECK_EN: output_pc = 12 and misalign = 1.
  - Next load of 8: misalign = 0.
  - Without the macro: output_pc = 13.
- Wrap: load 32'hFFFF_FFFC -> pc_plus4 = 32'h0000_0000.
- Mid-run reset: while output_pc = 16, assert rst for 1 edge with pc_en = 1 -> output_pc = 0 next cycle; loads resume after.
